// File: rtl/bpu_pkg.sv
// Shared definitions for the branch predictor table controller.
package bpu_pkg;
  localparam int IDX_W_DEF = 4;

  localparam logic [1:0] SN = 2'b00;
  localparam logic [1:0] WN = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;

  typedef enum logic {SWEEP, RUN} bpu_state_e;
endpackage

// File: rtl/sat_cnt2_next.sv
// 2-bit saturating counter next value: count up on taken, down on not-taken.
module sat_cnt2_next
  import bpu_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);
  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SN) nxt = cur - 2'd1;
    end
  end
endmodule

// File: rtl/bpu_table_ctrl.sv
// BHT controller: init/flush sweeps, table write arbitration, mispredict
// redirect and branch statistics.
module bpu_table_ctrl
  import bpu_pkg::*;
#(
  parameter int         IDX_W    = IDX_W_DEF,
  parameter logic [1:0] INIT_VAL = WN,
  parameter int         STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_req,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_taken,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_target,
  input  logic [31:0]       id_pc,
  input  logic [1:0]        tbl_rdata,
  output logic [IDX_W-1:0]  tbl_raddr,
  output logic              tbl_we,
  output logic [IDX_W-1:0]  tbl_waddr,
  output logic [1:0]        tbl_wdata,
  output logic              pred_en,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);
  bpu_state_e       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             br, mispred;
  logic [31:0]      next_pc;
  logic [1:0]       upd_val;

  assign tbl_raddr = ex_pc[IDX_W+1:2];
  assign br        = ex_valid & ex_is_branch;
  assign next_pc   = ex_taken ? ex_target : ex_pc + 32'd4;
  assign mispred   = ~rst & br & (id_pc != next_pc);

  assign redirect_valid = mispred;
  assign flush_if_id    = mispred;
  assign flush_id_ex    = mispred;
  assign redirect_pc    = mispred ? next_pc : 32'd0;

  sat_cnt2_next u_sat (
    .cur   (tbl_rdata),
    .taken (ex_taken),
    .nxt   (upd_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SWEEP;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Sweep owns the write port; flush_req only matters once running.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tbl_we    = 1'b0;
    tbl_waddr = idx;
    tbl_wdata = INIT_VAL;
    pred_en   = 1'b0;
    if (!rst) begin
      case (state)
        SWEEP: begin
          tbl_we  = 1'b1;
          idx_nxt = idx + 1'b1;
          if (idx == {IDX_W{1'b1}}) state_nxt = RUN;
        end
        RUN: begin
          pred_en = 1'b1;
          if (flush_req) begin
            state_nxt = SWEEP;
            idx_nxt   = '0;
          end else if (br) begin
            tbl_we    = 1'b1;
            tbl_waddr = ex_pc[IDX_W+1:2];
            tbl_wdata = upd_val;
          end
        end
        default: state_nxt = SWEEP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (br && stat_branches != {STAT_W{1'b1}})
        stat_branches <= stat_branches + STAT_W'(1);
      if (mispred && stat_mispred != {STAT_W{1'b1}})
        stat_mispred <= stat_mispred + STAT_W'(1);
    end
  end
endmodule

// File: tb/tb_bpu_table_ctrl.sv
// Directed bench for bpu_table_ctrl with a cycle-level reference model.
module tb_bpu_table_ctrl;
  localparam int IDX_W  = 4;
  localparam int N      = 16;
  localparam int STAT_W = 4;
  localparam int SMAX   = 15;

  logic        clk = 0, rst = 1, flush_req = 0;
  logic        ex_valid = 0, ex_is_branch = 0, ex_taken = 0;
  logic [31:0] ex_pc = 0, ex_target = 0, id_pc = 0;
  logic [1:0]  tbl_rdata = 0;
  logic [IDX_W-1:0]  tbl_raddr, tbl_waddr;
  logic              tbl_we, pred_en, redirect_valid, flush_if_id, flush_id_ex;
  logic [1:0]        tbl_wdata;
  logic [31:0]       redirect_pc;
  logic [STAT_W-1:0] stat_branches, stat_mispred;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  // Reference model: sweep writes remaining (0 = running), stat counts.
  int m_left, m_br, m_mp;

  bpu_table_ctrl #(.IDX_W(IDX_W), .INIT_VAL(2'b01), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_pc(ex_pc),
    .ex_target(ex_target), .id_pc(id_pc), .tbl_rdata(tbl_rdata),
    .tbl_raddr(tbl_raddr), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
    .tbl_wdata(tbl_wdata), .pred_en(pred_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit br, mis, e_we;
      int nxt, e_addr, e_data, c;
      br  = ex_valid && ex_is_branch;
      nxt = ex_taken ? int'(ex_target) : int'(ex_pc + 32'd4);
      mis = !rst && br && (id_pc != 32'(nxt));
      e_we = 0; e_addr = 0; e_data = 0;
      if (!rst) begin
        if (m_left > 0) begin
          e_we = 1; e_addr = N - m_left; e_data = 1;
        end else if (!flush_req && br) begin
          c = int'(tbl_rdata);
          e_we = 1; e_addr = int'(ex_pc[31:2]) % N;
          e_data = ex_taken ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
        end
      end
      chk("m_raddr", 32'(tbl_raddr), 32'(int'(ex_pc[31:2]) % N));
      chk("m_we", 32'(tbl_we), 32'(e_we));
      if (e_we) begin
        chk("m_waddr", 32'(tbl_waddr), 32'(e_addr));
        chk("m_wdata", 32'(tbl_wdata), 32'(e_data));
      end
      chk("m_pred_en", 32'(pred_en), 32'(!rst && m_left == 0));
      chk("m_redir", 32'(redirect_valid), 32'(mis));
      chk("m_flush_if_id", 32'(flush_if_id), 32'(mis));
      chk("m_flush_id_ex", 32'(flush_id_ex), 32'(mis));
      chk("m_redir_pc", redirect_pc, mis ? 32'(nxt) : 32'd0);
      chk("m_stat_br", 32'(stat_branches), 32'(m_br));
      chk("m_stat_mp", 32'(stat_mispred), 32'(m_mp));
      if (rst) begin
        m_left = N; m_br = 0; m_mp = 0;
      end else begin
        if (br && m_br < SMAX) m_br++;
        if (mis && m_mp < SMAX) m_mp++;
        if (m_left > 0) m_left--;
        else if (flush_req) m_left = N;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_ex(input bit v, input bit b, input bit t, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic [31:0] id, input logic [1:0] rd);
    ex_valid = v; ex_is_branch = b; ex_taken = t;
    ex_pc = pc; ex_target = tgt; id_pc = id; tbl_rdata = rd;
  endtask

  typedef struct {bit v; bit b; bit t; logic [31:0] pc; logic [31:0] tgt;
                  logic [31:0] id; logic [1:0] rd;} vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 1, 0, 32'h100, 32'h200, 32'h104, 2'b00}; // NT correct, floor at 0
    vecs[1] = '{1, 1, 1, 32'h104, 32'h300, 32'h108, 2'b00}; // taken, wrong path
    vecs[2] = '{1, 1, 0, 32'hFFFF_FFFC, 32'h10, 32'h0, 2'b01}; // pc+4 wraps
    vecs[3] = '{1, 1, 1, 32'h3C, 32'h3C, 32'h3C, 2'b10};   // taken loop to self
    vecs[4] = '{1, 0, 1, 32'h20, 32'h999, 32'h0, 2'b11};   // non-branch
    vecs[5] = '{0, 1, 1, 32'h24, 32'h500, 32'h0, 2'b01};   // invalid
    vecs[6] = '{1, 1, 0, 32'h78, 32'h0, 32'h80, 2'b11};    // NT, ST -> WT
    vecs[7] = '{1, 1, 1, 32'h7C, 32'h40, 32'h80, 2'b10};   // taken mispredict

    m_left = N; m_br = 0; m_mp = 0;
    cyc();
    chk_en = 1;
    cyc();
    rst = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("init_we", 32'(tbl_we), 32'd1);
      chk("init_addr", 32'(tbl_waddr), 32'(i));
      chk("init_data", 32'(tbl_wdata), 32'd1);
      chk("init_pred_off", 32'(pred_en), 32'd0);
      cyc();
    end
    @(negedge clk);
    chk("pred_on", 32'(pred_en), 32'd1);

    cyc();
    set_ex(1, 1, 1, 32'h40, 32'h80, 32'h80, 2'b11);
    @(negedge clk);
    chk("t2_we", 32'(tbl_we), 32'd1);
    chk("t2_addr", 32'(tbl_waddr), 32'd0);
    chk("t2_data", 32'(tbl_wdata), 32'd3);
    chk("t2_redir", 32'(redirect_valid), 32'd0);
    cyc();
    set_ex(1, 1, 0, 32'h44, 32'h0, 32'h80, 2'b10);
    @(negedge clk);
    chk("t2_branches", 32'(stat_branches), 32'd1);
    chk("t3_data", 32'(tbl_wdata), 32'd1);
    chk("t3_redir", 32'(redirect_valid), 32'd1);
    chk("t3_pc", redirect_pc, 32'h48);
    chk("t3_flushes", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
    cyc();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_branches", 32'(stat_branches), 32'd2);
    chk("t3_mispred", 32'(stat_mispred), 32'd1);

    for (int i = 0; i < 8; i++) begin
      set_ex(vecs[i].v, vecs[i].b, vecs[i].t, vecs[i].pc, vecs[i].tgt, vecs[i].id, vecs[i].rd);
      cyc();
    end

    // flush with a same-cycle branch, then a stray flush inside the sweep
    set_ex(1, 1, 1, 32'h44, 32'h90, 32'h90, 2'b01);
    flush_req = 1;
    @(negedge clk);
    chk("flush_no_ex_write", 32'(tbl_we), 32'd0);
    cyc();
    set_ex(1, 1, 0, 32'h44, 32'h0, 32'h80, 2'b10);
    for (int i = 0; i < N; i++) begin
      flush_req = (i == 5);
      @(negedge clk);
      chk("fl_addr", 32'(tbl_waddr), 32'(i));
      chk("fl_data", 32'(tbl_wdata), 32'd1);
      cyc();
    end
    flush_req = 0;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("fl_pred_on", 32'(pred_en), 32'd1);

    // reset in the middle of a sweep
    flush_req = 1;
    cyc();
    flush_req = 0;
    for (int i = 0; i < 9; i++) cyc();
    @(negedge clk);
    chk("rst_at9", 32'(tbl_waddr), 32'd9);
    rst = 1;
    cyc();
    rst = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (i == 0) chk("rst_stats", {16'(stat_branches), 16'(stat_mispred)}, 32'd0);
      chk("rst_sweep_addr", 32'(tbl_waddr), 32'(i));
      chk("rst_pred_off", 32'(pred_en), 32'd0);
      cyc();
    end
    @(negedge clk);
    chk("rst_pred_on", 32'(pred_en), 32'd1);

    // saturation, then an invalid branch
    set_ex(1, 1, 1, 32'h10, 32'h50, 32'h14, 2'b01);
    for (int i = 0; i < 17; i++) cyc();
    set_ex(0, 1, 1, 32'h10, 32'h50, 32'h14, 2'b01);
    @(negedge clk);
    chk("sat_mispred", 32'(stat_mispred), 32'd15);
    chk("sat_branches", 32'(stat_branches), 32'd15);
    chk("inv_no_we", 32'(tbl_we), 32'd0);
    cyc();
    cyc();
    @(negedge clk);
    chk("inv_mispred", 32'(stat_mispred), 32'd15);
    chk("inv_redir", 32'(redirect_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bpu_table_ctrl.md
Name: bpu_table_ctrl

Overview:
- Controller sitting between the EX stage, the 2-bit branch history table and the hazard/NPC logic.
- Sequences table initialisation and flush sweeps after reset or on request, and computes saturating counter updates from resolved branches.
- Arbitrates the single table write port between the sweep and EX updates.
- Detects mispredictions in EX, drives redirect/flush signals, and keeps branch and mispredict statistics counters.

Parameters:
IDX_W, 4, table index width (2^IDX_W entries, index = pc[IDX_W+1:2])
INIT_VAL, 2'b01, counter value written by sweeps (weakly not-taken)
STAT_W, 32, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush_req  in  1  one-cycle pulse: re-initialise whole table (FENCE.I / debug)
ex_valid  in  1  EX stage holds a real instruction
ex_is_branch  in  1  EX instruction is a conditional branch (BranchType != 0)
ex_taken  in  1  branch resolved taken in EX
ex_pc  in  32  PC of EX instruction
ex_target  in  32  resolved branch target
id_pc  in  32  PC currently in ID (the predicted successor)
tbl_rdata  in  2  current counter at tbl_raddr (combinational read)
tbl_raddr  out  IDX_W  ex_pc[IDX_W+1:2]
tbl_we  out  1  table write enable
tbl_waddr  out  IDX_W  write index
tbl_wdata  out  2  write data
pred_en  out  1  predictions may be used by fetch; 0 forces not-taken
redirect_valid  out  1  mispredict detected this cycle
redirect_pc  out  32  correct next PC
flush_if_id  out  1  squash IF/ID
flush_id_ex  out  1  squash ID/EX
stat_branches  out  STAT_W  resolved conditional branches
stat_mispred  out  STAT_W  mispredicted branches

Behaviour:
- FSM states: SWEEP, RUN. Sweep index register idx[IDX_W-1:0].
- rst high: state=SWEEP, idx=0, both stats=0. tbl_we=0, pred_en=0. Redirect outputs are 0 during rst.
- SWEEP:
  - tbl_we=1, waddr=idx, wdata=INIT_VAL; idx increments each cycle.
  - When idx==2^IDX_W-1, the write occurs, state->RUN, idx->0.
  - A full sweep takes exactly 2^IDX_W cycles (16 by default). pred_en=1 from the cycle after the last write.
- SWEEP arbitration:
  - EX updates are dropped, so no table write from EX.
  - Stats and redirect still operate normally.
  - flush_req is ignored; the sweep continues without restart.
- RUN:
  - pred_en=1.
  - flush_req=1 -> state->SWEEP, idx=0 next cycle. Any same-cycle EX update is dropped (flush wins).
  - Otherwise, when ex_valid & ex_is_branch: tbl_we=1, waddr=ex_pc[IDX_W+1:2].
  - wdata is the saturating update of tbl_rdata: taken -> min(3, c+1); not taken -> max(0, c-1).
- Misprediction check, combinational, same cycle as EX, any state:
  - Taken: mispredict when id_pc != ex_target; redirect_pc=ex_target.
  - Not taken: mispredict when id_pc != ex_pc+4 (32-bit wrap); redirect_pc=ex_pc+4.
  - On mispredict: redirect_valid=flush_if_id=flush_id_ex=1. Otherwise all three are 0 and redirect_pc=0.
  - Non-branch or ex_valid=0: no check, no update, no stat change.
- Stats, registered:
  - stat_branches +1 per valid branch; stat_mispred +1 per mispredict.
  - Both saturate at 2^STAT_W-1, no wrap.
  - Cleared only by rst; flush_req does not clear them.
- rst during a sweep restarts the sweep at index 0 after rst deasserts.

Decomposition:
- Shared package bpu_pkg: counter encodings SN=2'b00, WN=2'b01, WT=2'b10, ST=2'b11; state enum {SWEEP, RUN}; IDX_W default.
- Sub-module sat_cnt2_next: combinational 2-bit saturating next-value function, reused by the table datapath.
- Stats counters stay inline.

Test Plan:
- Reset released at cycle 0 -> tbl_we=1 for cycles 0..15 with waddr 0..15 and wdata=2'b01; pred_en=0 until cycle 16, then 1.
- RUN, branch ex_pc=0x40, taken, tbl_rdata=2'b11, ex_target=0x80, id_pc=0x80 -> waddr=0, wdata=2'b11, redirect_valid=0, stat_branches+1.
- RUN, ex_pc=0x44, not taken, tbl_rdata=2'b10, id_pc=0x80 -> wdata=2'b01, redirect_valid=1, redirect_pc=0x48, both flushes=1, stat_mispred+1.
- flush_req in RUN with a same-cycle valid branch -> no EX write; next 16 cycles sweep writes 2'b01. flush_req at sweep cycle 5 -> ignored, RUN resumes after cycle 15.
- rst asserted at sweep index 9 -> idx=0, stats=0; the sweep restarts and takes a full 16 cycles.
- Force stat_mispred to 2^32-1, then inject a mispredict -> value stays 0xFFFFFFFF; ex_valid=0 with ex_is_branch=1 -> no write, no stat change.
